// File: rtl/divide_seq_ctrl.sv
// Sequencing controller for divide_f32: accepts operand pairs, pulses the
// divider reset, waits for convergence (or timeout) and returns the quotient.
module divide_seq_ctrl #(
    parameter int unsigned RST_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 1024,
    parameter int unsigned CNT_W      = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_num,
    input  logic [31:0]      in_den,
    output logic             div_rst,
    output logic [31:0]      div_num,
    output logic [31:0]      div_den,
    input  logic             div_rdy,
    input  logic [31:0]      div_quo,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_quo,
    output logic             out_err,
    output logic [CNT_W-1:0] out_cycles,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [31:0]      QNAN      = 32'h7fc00000;

    state_e           state_q, state_d;
    logic [31:0]      num_q, num_d;
    logic [31:0]      den_q, den_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             div_rst_q, div_rst_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_quo_q, out_quo_d;
    logic             out_err_q, out_err_d;
    logic [CNT_W-1:0] out_cycles_q, out_cycles_d;
    logic             bypass;

    assign in_ready   = (state_q == IDLE) && !rst;
    assign busy       = (state_q != IDLE);
    assign div_rst    = div_rst_q;
    assign div_num    = num_q;
    assign div_den    = den_q;
    assign out_valid  = out_valid_q;
    assign out_quo    = out_quo_q;
    assign out_err    = out_err_q;
    assign out_cycles = out_cycles_q;

    // Signed zero over a nonzero denominator never needs the divider.
    assign bypass  = (in_num[30:0] == 31'd0) && (in_den[30:0] != 31'd0);
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d      = state_q;
        num_d        = num_q;
        den_d        = den_q;
        cnt_d        = cnt_q;
        div_rst_d    = div_rst_q;
        out_valid_d  = out_valid_q;
        out_quo_d    = out_quo_q;
        out_err_d    = out_err_q;
        out_cycles_d = out_cycles_q;
        case (state_q)
            IDLE: begin
                div_rst_d = 1'b1;
                if (in_valid && in_ready) begin
                    num_d = in_num;
                    den_d = in_den;
                    if (bypass) begin
                        state_d      = DONE;
                        out_valid_d  = 1'b1;
                        out_quo_d    = {in_num[31] ^ in_den[31], 31'd0};
                        out_err_d    = 1'b0;
                        out_cycles_d = '0;
                    end else begin
                        state_d = LOAD;
                        cnt_d   = '0;
                    end
                end
            end
            LOAD: begin
                div_rst_d = 1'b1;
                if (cnt_q == LOAD_LAST) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    div_rst_d = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RUN: begin
                div_rst_d = 1'b0;
                cnt_d     = (cnt_q == TIMEOUT_C) ? cnt_q : cnt_inc;
                // Convergence takes priority over a timeout on the same edge.
                if (div_rdy) begin
                    state_d      = DONE;
                    div_rst_d    = 1'b1;
                    out_valid_d  = 1'b1;
                    out_quo_d    = div_quo;
                    out_err_d    = 1'b0;
                    out_cycles_d = cnt_inc;
                end else if (cnt_inc == TIMEOUT_C) begin
                    state_d      = DONE;
                    div_rst_d    = 1'b1;
                    out_valid_d  = 1'b1;
                    out_quo_d    = QNAN;
                    out_err_d    = 1'b1;
                    out_cycles_d = TIMEOUT_C;
                end
            end
            DONE: begin
                div_rst_d   = 1'b1;
                out_valid_d = 1'b1;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            num_q        <= '0;
            den_q        <= '0;
            cnt_q        <= '0;
            div_rst_q    <= 1'b1;
            out_valid_q  <= 1'b0;
            out_quo_q    <= '0;
            out_err_q    <= 1'b0;
            out_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            num_q        <= num_d;
            den_q        <= den_d;
            cnt_q        <= cnt_d;
            div_rst_q    <= div_rst_d;
            out_valid_q  <= out_valid_d;
            out_quo_q    <= out_quo_d;
            out_err_q    <= out_err_d;
            out_cycles_q <= out_cycles_d;
        end
    end

endmodule

// File: tb/tb_divide_seq_ctrl.sv
// Directed bench for divide_seq_ctrl; the bench itself stands in for divide_f32,
// raising div_rdy after a chosen number of RUN cycles.
module tb_divide_seq_ctrl;

    localparam int unsigned RST_CYCLES = 2;
    localparam int unsigned TIMEOUT    = 16;
    localparam int unsigned CNT_W      = 11;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_num;
    logic [31:0]      in_den;
    logic             div_rst;
    logic [31:0]      div_num;
    logic [31:0]      div_den;
    logic             div_rdy;
    logic [31:0]      div_quo;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_quo;
    logic             out_err;
    logic [CNT_W-1:0] out_cycles;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    divide_seq_ctrl #(
        .RST_CYCLES(RST_CYCLES),
        .TIMEOUT   (TIMEOUT),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_num    (in_num),
        .in_den    (in_den),
        .div_rst   (div_rst),
        .div_num   (div_num),
        .div_den   (div_den),
        .div_rdy   (div_rdy),
        .div_quo   (div_quo),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_quo   (out_quo),
        .out_err   (out_err),
        .out_cycles(out_cycles),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the output handshake.
    // lat = RUN cycle in which the stub raises div_rdy (0 = never).
    task automatic run_op(input string tag, input logic [31:0] num, input logic [31:0] den,
                          input int lat, input logic [31:0] quo, input logic [31:0] exp_quo,
                          input logic exp_err, input int exp_cycles, input bit exp_bypass,
                          input int hold);
        int  c;
        int  run_cnt;
        int  exp_lat;
        bit  seen;
        logic [31:0] q_hold;
        exp_lat   = exp_bypass ? 1 : 1 + RST_CYCLES + exp_cycles;
        c         = 0;
        run_cnt   = 0;
        seen      = 0;
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        in_num    = num;
        in_den    = den;
        #1 chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        while (!seen && c < 200) begin
            @(negedge clk);
            c++;
            in_valid = 1'b0;
            if (!div_rst) begin
                run_cnt++;
                div_rdy = (lat > 0) && (run_cnt >= lat);
                div_quo = quo;
            end else begin
                div_rdy = 1'b0;
            end
            if (out_valid) seen = 1;
        end
        chk({tag, "_seen"},    32'(seen),       32'd1);
        chk({tag, "_latency"}, 32'(c),          32'(exp_lat));
        chk({tag, "_quo"},     out_quo,         exp_quo);
        chk({tag, "_err"},     32'(out_err),    32'(exp_err));
        chk({tag, "_cycles"},  32'(out_cycles), 32'(exp_cycles));
        chk({tag, "_runlow"},  32'(run_cnt),    32'(exp_cycles));
        chk({tag, "_divnum"},  div_num,         num);
        chk({tag, "_divden"},  div_den,         den);
        q_hold = exp_quo;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_quo"},   out_quo,        q_hold);
            chk({tag, "_hold_inrdy"}, 32'(in_ready),  32'd0);
            chk({tag, "_hold_rst"},   32'(div_rst),   32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_idle_ready"}, 32'(in_ready),  32'd1);
        chk({tag, "_idle_busy"},  32'(busy),      32'd0);
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_num    = '0;
        in_den    = '0;
        div_rdy   = 1'b0;
        div_quo   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid",  32'(out_valid),  32'd0);
        chk("rst_out_quo",    out_quo,         32'd0);
        chk("rst_out_err",    32'(out_err),    32'd0);
        chk("rst_out_cycles", 32'(out_cycles), 32'd0);
        chk("rst_div_rst",    32'(div_rst),    32'd1);
        chk("rst_in_ready",   32'(in_ready),   32'd0);
        chk("rst_busy",       32'(busy),       32'd0);
        chk("rst_div_num",    div_num,         32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // 4/2 with a 7-cycle divider
        run_op("div4_2", 32'h40800000, 32'h40000000, 7, 32'h40000000,
               32'h40000000, 1'b0, 7, 1'b0, 0);
        // zero numerator bypass, signs combine
        run_op("byp_pos", 32'h00000000, 32'h4effffff, 0, 32'h0,
               32'h00000000, 1'b0, 0, 1'b1, 0);
        run_op("byp_neg", 32'h80000000, 32'h40000000, 0, 32'h0,
               32'h80000000, 1'b0, 0, 1'b1, 0);
        run_op("byp_negneg", 32'h80000000, 32'hc0000000, 0, 32'h0,
               32'h00000000, 1'b0, 0, 1'b1, 0);
        // 0/0 is not bypassed
        run_op("zero_zero", 32'h00000000, 32'h00000000, 3, 32'h7fc00000,
               32'h7fc00000, 1'b0, 3, 1'b0, 0);
        // divider never converges
        run_op("timeout", 32'h3f800000, 32'h40400000, 0, 32'h0,
               32'h7fc00000, 1'b1, 16, 1'b0, 0);
        // rdy arrives on the timeout edge
        run_op("rdy_at_to", 32'h3f800000, 32'h40400000, 16, 32'h12345678,
               32'h12345678, 1'b0, 16, 1'b0, 0);
        // backpressure then back-to-back
        run_op("bp_4_3", 32'h40800000, 32'h40400000, 5, 32'h3faaaaab,
               32'h3faaaaab, 1'b0, 5, 1'b0, 5);
        run_op("b2b", 32'h43410000, 32'h43c10000, 4, 32'h3f000000,
               32'h3f000000, 1'b0, 4, 1'b0, 0);

        // reset in the middle of RUN
        in_valid  = 1'b1;
        in_num    = 32'h40800000;
        in_den    = 32'h40000000;
        n = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while (n < 3 && checks < 100000) begin
            @(negedge clk);
            if (!div_rst) n++;
            if (busy == 1'b0) break;
        end
        chk("midrst_reached_run", 32'(n), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_div_rst",   32'(div_rst),   32'd1);
        chk("midrst_busy",      32'(busy),      32'd0);
        chk("midrst_in_ready",  32'(in_ready),  32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_after_in_ready",  32'(in_ready),  32'd1);
        chk("midrst_after_out_valid", 32'(out_valid), 32'd0);
        run_op("after_rst", 32'h40800000, 32'h40000000, 6, 32'h40000000,
               32'h40000000, 1'b0, 6, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/divide_seq_ctrl.md
Name: divide_seq_ctrl

Overview:
Sequencing front/back end for the iterative divide_f32 unit. Accepts float32 operand pairs on a valid/ready input stream and starts divide_f32 by pulsing its reset. It waits for the unit's rdy, then presents the quotient plus a cycle count on a valid/ready output stream. Zero numerators bypass the divider. A divider that never converges produces an error result after a bounded timeout.

Parameters:
RST_CYCLES, 2, number of cycles div_rst is held high in LOAD before release (min 1)
TIMEOUT, 1024, max RUN cycles to wait for div_rdy before error
CNT_W, 11, width of cycle counter/out_cycles; must hold TIMEOUT

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  controller can accept operands
in_num  input  32  float32 numerator
in_den  input  32  float32 denominator
div_rst  output  1  reset/start to divide_f32 (high = held idle)
div_num  output  32  numerator to divide_f32
div_den  output  32  denominator to divide_f32
div_rdy  input  1  divide_f32 converged flag
div_quo  input  32  divide_f32 quotient
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_quo  output  32  float32 quotient
out_err  output  1  result produced by timeout
out_cycles  output  CNT_W  RUN cycles spent (0 for bypass)
busy  output  1  state != IDLE

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset (rst sampled high at posedge) forces: state=IDLE, out_valid=0, out_quo=0, out_err=0, out_cycles=0, div_rst=1, latched operands=0, counters=0. in_ready=0 whenever rst is high.
- Reset mid-operation (LOAD/RUN/DONE) abandons the operation. No output is produced. div_rst returns high.
- States: IDLE, LOAD, RUN, DONE. All outputs are registered except in_ready=(state==IDLE)&&!rst and busy.
- div_num/div_den are continuously driven from the latched operand registers.
- IDLE: div_rst=1. Accept on in_valid&&in_ready: latch in_num/in_den.
  - Bypass case: in_num[30:0]==0 and in_den[30:0]!=0. Next state is DONE with out_quo={in_num[31]^in_den[31],31'b0}, out_err=0, out_cycles=0. div_rst stays high throughout.
  - Otherwise the next state is LOAD and the LOAD counter is cleared.
- LOAD: div_rst=1 for exactly RST_CYCLES cycles, then go to RUN. div_rst=0 takes effect on the first RUN cycle. The RUN counter is set to 0.
- RUN: div_rst=0. At each posedge the counter increments (saturating at TIMEOUT).
  - If div_rdy=1: capture out_quo=div_quo, out_err=0, out_cycles=counter+1, go to DONE.
  - Else, if counter+1==TIMEOUT: out_quo=32'h7fc00000, out_err=1, out_cycles=TIMEOUT, go to DONE.
  - If div_rdy rises on the same edge where the timeout would fire, div_rdy wins.
- DONE: out_valid=1, div_rst=1, and out_quo/out_err/out_cycles are held stable while out_ready=0. On out_valid&&out_ready, out_valid=0 next cycle and the state returns to IDLE. The earliest next acceptance is the cycle after that.
- Only one operation is in flight. No input acceptance occurs outside IDLE, so there are no simultaneous accept/complete hazards.
- Denominator zero or infinite operands are not special-cased except as above; the divider's result is passed through. 0/0 goes through the divider.
- Latency:
  - Normal path: accept-to-out_valid = 1 + RST_CYCLES + out_cycles cycles.
  - Bypass path: out_valid is asserted on the cycle after accept.

Test Plan:
- Real divide_f32, in_num=0x40800000, in_den=0x40000000, out_ready=1 -> out_quo=0x40000000, out_err=0, out_cycles = divider convergence count, single out_valid pulse, div_rst low only during RUN.
- in_num=0x00000000, in_den=0x4effffff -> out_valid one cycle after accept, out_quo=0x00000000, out_cycles=0, div_rst never low. Also in_num=0x80000000, in_den=0x40000000 -> out_quo=0x80000000.
- Stub div_rdy tied 0, TIMEOUT=16 -> out_err=1, out_quo=0x7fc00000, out_cycles=16, out_valid at accept+1+RST_CYCLES+16.
- Backpressure: 4/3 (0x40800000/0x40400000) with out_ready=0 for 5 cycles after out_valid -> out_quo=0x3faaaaab held stable, in_ready=0, then completes on out_ready; back-to-back second pair 0x43410000/0x43c10000 -> 0x3f000000.
- Assert rst for 1 cycle mid-RUN -> no out_valid, div_rst=1, in_ready=1 the cycle after rst drops, then a fresh 4/2 gives 0x40000000.
- Stub div_rdy=1 on the edge where counter+1==TIMEOUT, div_quo=0x12345678 -> out_quo=0x12345678, out_err=0.
